// File: rtl/mem_block_responder_pkg.sv
// Shared definitions for the memory-side block responder: default widths
// and the FSM state encoding.
package mem_block_responder_pkg;

  localparam int BW_WORD_ADDR = 16;
  localparam int BW_BLOCK     = 3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WR_FILL  = 2'd1,
    ST_WR_DRAIN = 2'd2,
    ST_RD_XFER  = 2'd3
  } state_t;

endpackage

// File: rtl/mem_block_responder_fifo.sv
// Block-deep word FIFO with first-word fall-through head and synchronous
// flush. The head reads as zero while the FIFO is empty.
module block_word_fifo #(
  parameter int DEPTH_LOG2 = 3,
  parameter int WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  flush,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      head_data,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem_array [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_reg;
  logic [DEPTH_LOG2-1:0] rd_ptr_reg;
  logic [DEPTH_LOG2:0]   count_reg;
  logic                  do_push;
  logic                  do_pop;

  assign full      = (count_reg == (DEPTH_LOG2 + 1)'(DEPTH));
  assign empty     = (count_reg == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign count     = count_reg;
  assign head_data = empty ? '0 : mem_array[rd_ptr_reg];

  // Storage write; contents need no reset because empty masks the head.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_array[wr_ptr_reg] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; push+pop together leaves count unchanged.
  always_ff @(posedge clk) begin
    if (srst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + DEPTH_LOG2'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + DEPTH_LOG2'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (DEPTH_LOG2 + 1)'(1);
        2'b01:   count_reg <= count_reg - (DEPTH_LOG2 + 1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/mem_block_responder.sv
// Memory-side responder: accepts one word/block transaction from the L2,
// buffers it in a block-deep FIFO and replays it over a word-wide memory port.
module mem_block_responder
  import mem_block_responder_pkg::*;
#(
  parameter int BW_ADDR = BW_WORD_ADDR,
  parameter int BW_BLK  = BW_BLOCK
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               req_i,
  input  logic               req_block_i,
  input  logic               rw_i,
  input  logic [BW_ADDR-1:0] add_i,
  input  logic               write_i,
  input  logic [31:0]        data_i,
  input  logic               read_i,
  output logic               ready_req_o,
  output logic               ready_write_o,
  output logic               ready_read_o,
  output logic [31:0]        data_o,
  output logic               mem_req_o,
  output logic               mem_rw_o,
  output logic [BW_ADDR-1:0] mem_add_o,
  output logic [31:0]        mem_data_o,
  input  logic               mem_gnt_i,
  input  logic               mem_rvalid_i,
  input  logic [31:0]        mem_rdata_i,
  output logic               err_o
);
  localparam int            CW        = BW_BLK + 1;
  localparam logic [CW-1:0] BLK_WORDS = CW'(1 << BW_BLK);
  localparam logic [CW-1:0] ONE       = CW'(1);

  state_t             state_reg, state_next;
  logic [BW_ADDR-1:0] base_reg, base_next;
  logic [CW-1:0]      n_reg, n_next;
  logic [CW-1:0]      rx_cnt_reg, rx_cnt_next;
  logic [CW-1:0]      issue_reg, issue_next;
  logic [CW-1:0]      out_reg, out_next;
  logic [CW-1:0]      pop_cnt_reg, pop_cnt_next;
  logic               err_reg, err_next;

  logic               fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [31:0]        fifo_push_data, fifo_head;
  logic [CW-1:0]      fifo_count;
  logic [BW_BLK-1:0]  blk_offset;
  logic [CW:0]        in_flight;
  logic               rd_issue, rd_return;

  block_word_fifo #(
    .DEPTH_LOG2 (BW_BLK),
    .WIDTH      (32)
  ) u_fifo (
    .clk       (clock_i),
    .srst      (reset_i),
    .flush     (fifo_flush),
    .push      (fifo_push),
    .push_data (fifo_push_data),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Offset arithmetic stays inside the block so the tag bits never carry.
  assign blk_offset = base_reg[BW_BLK-1:0] + issue_reg[BW_BLK-1:0];
  // Words that already hold or will need a FIFO slot.
  assign in_flight  = {1'b0, out_reg} + {1'b0, fifo_count};
  assign data_o     = fifo_head;
  assign err_o      = err_reg;

  // Next-state, handshake outputs and counter updates.
  always_comb begin
    state_next     = state_reg;
    base_next      = base_reg;
    n_next         = n_reg;
    rx_cnt_next    = rx_cnt_reg;
    issue_next     = issue_reg;
    out_next       = out_reg;
    pop_cnt_next   = pop_cnt_reg;
    err_next       = err_reg;
    ready_req_o    = 1'b0;
    ready_write_o  = 1'b0;
    ready_read_o   = 1'b0;
    mem_req_o      = 1'b0;
    mem_rw_o       = 1'b0;
    mem_add_o      = '0;
    mem_data_o     = '0;
    fifo_push      = 1'b0;
    fifo_pop       = 1'b0;
    fifo_flush     = 1'b0;
    fifo_push_data = mem_rdata_i;
    rd_issue       = 1'b0;
    rd_return      = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        ready_req_o = 1'b1;
        if (req_i) begin
          fifo_flush   = 1'b1;
          base_next    = req_block_i ? {add_i[BW_ADDR-1:BW_BLK], {BW_BLK{1'b0}}} : add_i;
          n_next       = req_block_i ? BLK_WORDS : ONE;
          rx_cnt_next  = '0;
          issue_next   = '0;
          out_next     = '0;
          pop_cnt_next = '0;
          state_next   = rw_i ? ST_WR_FILL : ST_RD_XFER;
        end
      end
      ST_WR_FILL: begin
        ready_write_o  = (rx_cnt_reg < n_reg) && !fifo_full;
        fifo_push_data = data_i;
        if (write_i && ready_write_o) begin
          fifo_push   = 1'b1;
          rx_cnt_next = rx_cnt_reg + ONE;
          if (rx_cnt_next == n_reg) begin
            state_next = ST_WR_DRAIN;
          end
        end
      end
      ST_WR_DRAIN: begin
        mem_req_o  = 1'b1;
        mem_rw_o   = 1'b1;
        mem_add_o  = {base_reg[BW_ADDR-1:BW_BLK], blk_offset};
        mem_data_o = fifo_head;
        if (mem_gnt_i) begin
          fifo_pop   = 1'b1;
          issue_next = issue_reg + ONE;
          if (issue_next == n_reg) begin
            state_next = ST_IDLE;
          end
        end
      end
      ST_RD_XFER: begin
        // Only request when a FIFO slot is guaranteed for the returning word.
        mem_req_o = (issue_reg < n_reg) && (in_flight < {1'b0, BLK_WORDS});
        if (mem_req_o) begin
          mem_add_o = {base_reg[BW_ADDR-1:BW_BLK], blk_offset};
        end
        rd_issue = mem_req_o && mem_gnt_i;
        if (rd_issue) begin
          issue_next = issue_reg + ONE;
        end
        ready_read_o = !fifo_empty;
        if (read_i && ready_read_o) begin
          fifo_pop     = 1'b1;
          pop_cnt_next = pop_cnt_reg + ONE;
          if (pop_cnt_next == n_reg) begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // Read data only counts against an outstanding request; strays are errors.
    if (mem_rvalid_i) begin
      if (out_reg != '0) begin
        rd_return = 1'b1;
        fifo_push = 1'b1;
      end else begin
        err_next = 1'b1;
      end
    end

    if (rd_issue && !rd_return) begin
      out_next = out_reg + ONE;
    end else if (!rd_issue && rd_return) begin
      out_next = out_reg - ONE;
    end

    if (write_i && !ready_write_o) begin
      err_next = 1'b1;
    end
    if (read_i && !ready_read_o) begin
      err_next = 1'b1;
    end
  end

  // State and counter registers; reset aborts any transaction in progress.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_reg   <= ST_IDLE;
      base_reg    <= '0;
      n_reg       <= '0;
      rx_cnt_reg  <= '0;
      issue_reg   <= '0;
      out_reg     <= '0;
      pop_cnt_reg <= '0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      base_reg    <= base_next;
      n_reg       <= n_next;
      rx_cnt_reg  <= rx_cnt_next;
      issue_reg   <= issue_next;
      out_reg     <= out_next;
      pop_cnt_reg <= pop_cnt_next;
      err_reg     <= err_next;
    end
  end

endmodule

// File: tb/tb_mem_block_responder.sv
// Scoreboard bench for mem_block_responder: directed transactions push
// expected memory-port and L2-read responses; a monitor pops and compares.
module tb_mem_block_responder;

  logic        clock_i = 1'b0;
  logic        reset_i;
  logic        req_i, req_block_i, rw_i;
  logic [15:0] add_i;
  logic        write_i;
  logic [31:0] data_i;
  logic        read_i;
  logic        ready_req_o, ready_write_o, ready_read_o;
  logic [31:0] data_o;
  logic        mem_req_o, mem_rw_o;
  logic [15:0] mem_add_o;
  logic [31:0] mem_data_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        err_o;

  mem_block_responder #(.BW_ADDR(16), .BW_BLK(3)) dut (
    .clock_i       (clock_i),
    .reset_i       (reset_i),
    .req_i         (req_i),
    .req_block_i   (req_block_i),
    .rw_i          (rw_i),
    .add_i         (add_i),
    .write_i       (write_i),
    .data_i        (data_i),
    .read_i        (read_i),
    .ready_req_o   (ready_req_o),
    .ready_write_o (ready_write_o),
    .ready_read_o  (ready_read_o),
    .data_o        (data_o),
    .mem_req_o     (mem_req_o),
    .mem_rw_o      (mem_rw_o),
    .mem_add_o     (mem_add_o),
    .mem_data_o    (mem_data_o),
    .mem_gnt_i     (mem_gnt_i),
    .mem_rvalid_i  (mem_rvalid_i),
    .mem_rdata_i   (mem_rdata_i),
    .err_o         (err_o)
  );

  always #5 clock_i = ~clock_i;

  typedef struct packed {
    logic        rw;
    logic [15:0] addr;
    logic [31:0] data;
  } mem_txn_t;

  int          checks   = 0;
  int          failures = 0;
  mem_txn_t    exp_mem_q[$];
  logic [31:0] exp_rd_q[$];
  logic [31:0] pipe_data_q[$];
  int unsigned pipe_due_q[$];
  logic [31:0] mem_img [0:1023];
  int unsigned cyc = 0;
  int          gnt_mode = 0;   // 0: always grant, 1: every other cycle, 2: never
  int unsigned rd_lat = 1;
  bit          tb_go = 1'b0;
  int          outst = 0;
  int          outst_max = 0;
  int          wr_grants = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic exp_mem(input logic rw, input logic [15:0] addr, input logic [31:0] data);
    mem_txn_t t;
    t.rw   = rw;
    t.addr = addr;
    t.data = data;
    exp_mem_q.push_back(t);
  endtask

  initial begin
    forever begin
      @(posedge clock_i);
      cyc++;
    end
  end

  // External memory model: grant decision and in-order read returns.
  initial begin
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    forever begin
      bit allow;
      @(negedge clock_i);
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
      if (pipe_due_q.size() > 0 && pipe_due_q[0] <= cyc) begin
        void'(pipe_due_q.pop_front());
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = pipe_data_q.pop_front();
      end
      case (gnt_mode)
        0:       allow = 1'b1;
        1:       allow = (cyc % 2 == 0);
        default: allow = 1'b0;
      endcase
      mem_gnt_i = tb_go && (mem_req_o === 1'b1) && allow;
      if (mem_gnt_i && !mem_rw_o) begin
        pipe_data_q.push_back(mem_img[mem_add_o[9:0]]);
        pipe_due_q.push_back(cyc + rd_lat);
      end
    end
  end

  // Monitor: compares every granted memory access and every L2 pop.
  initial begin
    forever begin
      mem_txn_t e;
      logic [31:0] d;
      @(negedge clock_i);
      #2;
      if (tb_go && !reset_i) begin
        if (mem_req_o && mem_gnt_i) begin
          if (mem_rw_o) wr_grants++;
          else outst++;
          if (exp_mem_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL mem_unexpected actual=rw%0d@0x%04h required=none", mem_rw_o, mem_add_o);
          end else begin
            e = exp_mem_q.pop_front();
            check("mem_rw", 32'(mem_rw_o), 32'(e.rw));
            check("mem_add", 32'(mem_add_o), 32'(e.addr));
            if (e.rw) check("mem_data", mem_data_o, e.data);
          end
        end
        if (mem_rvalid_i) outst--;
        if (outst > outst_max) outst_max = outst;
        if (read_i && ready_read_o) begin
          if (exp_rd_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL rd_unexpected actual=0x%08h required=none", data_o);
          end else begin
            d = exp_rd_q.pop_front();
            check("rd_data", data_o, d);
          end
        end
      end
    end
  end

  task automatic do_reset();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    pipe_data_q.delete();
    pipe_due_q.delete();
    outst = 0;
  endtask

  task automatic issue_req(input logic blk, input logic rw, input logic [15:0] addr);
    int c = 0;
    while (!ready_req_o && c < 100) begin
      tick();
      c++;
    end
    check("req_ready_wait", 32'(ready_req_o), 32'd1);
    req_i = 1'b1; req_block_i = blk; rw_i = rw; add_i = addr;
    tick();
    req_i = 1'b0; req_block_i = 1'b0; rw_i = 1'b0; add_i = '0;
  endtask

  task automatic write_words(input int n, input logic [31:0] first);
    int sent = 0;
    int c = 0;
    while (sent < n && c < 100) begin
      write_i = ready_write_o;
      data_i  = first + 32'(sent);
      if (write_i) sent++;
      tick();
      c++;
    end
    write_i = 1'b0;
    data_i  = '0;
    check("write_count", 32'(sent), 32'(n));
  endtask

  task automatic read_words(input int n, input int stall, output int first_lat, output int total);
    int popped = 0;
    int c = 0;
    first_lat = -1;
    while (popped < n && c < 200) begin
      if (ready_read_o && first_lat < 0) first_lat = c;
      read_i = (c >= stall) && ready_read_o;
      if (read_i) popped++;
      tick();
      c++;
    end
    read_i = 1'b0;
    while (!ready_req_o && c < 200) begin
      tick();
      c++;
    end
    total = c;
    check("read_count", 32'(popped), 32'(n));
  endtask

  task automatic wait_idle();
    int c = 0;
    while (!ready_req_o && c < 200) begin
      tick();
      c++;
    end
    check("idle_wait", 32'(ready_req_o), 32'd1);
  endtask

  initial begin
    int fl, tot;
    bit found;
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fl, tot;
    bit found;
    reset_i = 1'b1; req_i = 1'b0; req_block_i = 1'b0; rw_i = 1'b0; add_i = '0;
    write_i = 1'b0; data_i = '0; read_i = 1'b0;
    for (int i = 0; i < 1024; i++) mem_img[i] = 32'h0;
    mem_img[10'h040] = 32'hDEAD0001;
    for (int k = 0; k < 8; k++) begin
      mem_img[512 + k] = 32'hA0000000 + 32'(k);
      mem_img[792 + k] = 32'hC0DE0010 + 32'(k);
    end
    tick();
    tick();
    reset_i = 1'b0;
    tb_go   = 1'b1;

    // Reset state
    check("rst_ready_req", 32'(ready_req_o), 32'd1);
    check("rst_ready_write", 32'(ready_write_o), 32'd0);
    check("rst_ready_read", 32'(ready_read_o), 32'd0);
    check("rst_data_o", data_o, 32'd0);
    check("rst_mem_req", 32'(mem_req_o), 32'd0);
    check("rst_mem_rw", 32'(mem_rw_o), 32'd0);
    check("rst_mem_add", 32'(mem_add_o), 32'd0);
    check("rst_mem_data", mem_data_o, 32'd0);
    check("rst_err", 32'(err_o), 32'd0);

    // Single read, zero-wait memory
    exp_mem(1'b0, 16'h0040, 32'h0);
    exp_rd_q.push_back(32'hDEAD0001);
    issue_req(1'b0, 1'b0, 16'h0040);
    read_words(1, 0, fl, tot);
    check("single_rd_latency", 32'(fl), 32'd2);
    check("single_rd_total", 32'(tot), 32'd3);

    // Block write at 0x123 -> 0x120..0x127
    for (int k = 0; k < 8; k++) exp_mem(1'b1, 16'h0120 + 16'(k), 32'(k));
    issue_req(1'b1, 1'b1, 16'h0123);
    write_words(8, 32'h0);
    check("wr_first_req_latency", 32'(mem_req_o), 32'd1);
    check("wr_first_add", 32'(mem_add_o), 32'h0120);
    wait_idle();
    check("wr_queue_drained", 32'(exp_mem_q.size()), 32'd0);

    // Block read with toggling grant, slow memory, stalled L2
    gnt_mode = 1; rd_lat = 3; outst_max = 0;
    for (int k = 0; k < 8; k++) begin
      exp_mem(1'b0, 16'h0200 + 16'(k), 32'h0);
      exp_rd_q.push_back(32'hA0000000 + 32'(k));
    end
    issue_req(1'b1, 1'b0, 16'h0205);
    read_words(8, 30, fl, tot);
    check("stall_outst_le8", 32'(outst_max <= 8), 32'd1);
    check("stall_rd_drained", 32'(exp_rd_q.size()), 32'd0);

    // Streaming read: rvalid and read_i together every cycle, no bubbles
    gnt_mode = 0; rd_lat = 1;
    for (int k = 0; k < 8; k++) begin
      exp_mem(1'b0, 16'h0318 + 16'(k), 32'h0);
      exp_rd_q.push_back(32'hC0DE0010 + 32'(k));
    end
    issue_req(1'b1, 1'b0, 16'h031B);
    read_words(8, 0, fl, tot);
    check("stream_first_latency", 32'(fl), 32'd2);
    check("stream_total_cycles", 32'(tot), 32'd10);
    check("no_spurious_err", 32'(err_o), 32'd0);

    // Protocol errors
    read_i = 1'b1;
    tick();
    read_i = 1'b0;
    check("err_read_empty", 32'(err_o), 32'd1);
    check("err_read_ignored", 32'(ready_req_o), 32'd1);
    do_reset();
    check("err_cleared_by_reset", 32'(err_o), 32'd0);
    gnt_mode = 2;
    exp_mem(1'b1, 16'h0007, 32'h55AA55AA);
    issue_req(1'b0, 1'b1, 16'h0007);
    write_words(1, 32'h55AA55AA);
    req_i = 1'b1; rw_i = 1'b0; add_i = 16'h0099;
    tick();
    req_i = 1'b0; add_i = '0;
    check("busy_req_no_err", 32'(err_o), 32'd0);
    check("busy_req_ignored_add", 32'(mem_add_o), 32'h0007);
    check("busy_req_ignored_rw", 32'(mem_rw_o), 32'd1);
    write_i = 1'b1; data_i = 32'hFFFFFFFF;
    tick();
    write_i = 1'b0; data_i = '0;
    check("err_write_full", 32'(err_o), 32'd1);
    gnt_mode = 0;
    wait_idle();
    check("err_sticky", 32'(err_o), 32'd1);
    check("err_queue_drained", 32'(exp_mem_q.size()), 32'd0);

    // Reset during WR_DRAIN after 3 grants
    do_reset();
    read_i = 1'b1;
    tick();
    read_i = 1'b0;
    check("pre_reset_err", 32'(err_o), 32'd1);
    for (int k = 0; k < 8; k++) exp_mem(1'b1, 16'h03A0 + 16'(k), 32'h100 + 32'(k));
    issue_req(1'b1, 1'b1, 16'h03A5);
    wr_grants = 0;
    write_words(8, 32'h100);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clock_i);
      #3;
      if (wr_grants >= 3) found = 1'b1;
    end
    check("three_grants_seen", 32'(found), 32'd1);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    pipe_data_q.delete();
    pipe_due_q.delete();
    exp_mem_q.delete();
    check("abort_mem_req", 32'(mem_req_o), 32'd0);
    check("abort_ready_req", 32'(ready_req_o), 32'd1);
    check("abort_fifo_empty", 32'(ready_read_o), 32'd0);
    check("abort_data_o", data_o, 32'd0);
    check("abort_err", 32'(err_o), 32'd0);
    tick(); tick(); tick();
    check("abort_no_more_grants", 32'(wr_grants), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
